fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the architectural PC and issues one outstanding request at a time to instruction memory.
//  Buffers the returned word in a one-entry IF/ID output register with a valid/ready handshake to decode.
//  Accepts branch/jump redirects from execute and discards the stale in-flight response; computes pc+4 for decode/link.
// PARAMETERS
//  XLEN          32            data/address width
//  RESET_VECTOR  32'h0000_0000 PC after reset (must be 4-byte aligned)
// PORTS
//  clk_i              in   1     clock, rising edge
//  rst_i              in   1     synchronous, active-high reset
//  redirect_valid_i   in   1     execute redirects fetch this cycle
//  redirect_pc_i      in   XLEN  redirect target
//  imem_req_valid_o   out  1     fetch request valid
//  imem_req_ready_i   in   1     imem accepts request
//  imem_addr_o        out  XLEN  fetch address (= pc_q)
//  imem_rsp_valid_i   in   1     read data valid (1 rsp per accepted req, >=1 cycle later)
//  imem_rdata_i       in   32    instruction word
//  if_valid_o         out  1     IF/ID entry valid
//  id_ready_i         in   1     decode consumes entry
//  if_pc_o            out  XLEN  PC of buffered instruction
//  if_pc_plus4_o      out  XLEN  if_pc_o + 4
//  if_instr_o         out  32    buffered instruction
//  fetch_fault_o      out  1     sticky: misaligned redirect seen
// BEHAVIOUR
//  Reset (rst_i=1 at edge): pc_q=RESET_VECTOR, state=ISSUE, drop_q=0; all outputs 0 (if_pc_*/if_instr 0); requests start the cycle after.
//  States:
//  - ISSUE: imem_req_valid_o=1, imem_addr_o=pc_q; on handshake -> WAIT.
//  - WAIT: req_valid=0; on rsp_valid_i & !drop_q: capture {pc_q, pc_q+4, rdata}, pc_q<=pc_q+4, -> HOLD.
//  - HOLD: if_valid_o=1; payload stable until id_ready_i; on id_ready_i -> ISSUE (if_valid_o=0 next cycle).
//  - FAULT: no requests, if_valid_o=0, fetch_fault_o=1; exit only via rst_i.
//  Redirect (priority over every other event; target aligned):
//  - ISSUE, no handshake: pc_q<=target; stay ISSUE; imem tolerates addr change while valid.
//  - ISSUE, handshake same cycle: pc_q<=target, drop_q<=1, -> WAIT.
//  - WAIT, no rsp: pc_q<=target, drop_q<=1; stay WAIT.
//  - WAIT, rsp same cycle: response discarded, pc_q<=target, drop_q unchanged(0), -> ISSUE.
//  - HOLD: entry invalidated next cycle regardless of id_ready_i; pc_q<=target, -> ISSUE.
//  WAIT with drop_q=1 on rsp: discard, drop_q<=0, -> ISSUE (pc_q already target).
//  Misaligned redirect (redirect_pc_i[1:0]!=0), any state: -> FAULT, pc_q<=target, drop_q<=0, if_valid_o=0 next cycle.
//  Arithmetic: pc+4 modulo 2^XLEN (32'hFFFF_FFFC -> 0); no overflow flag.
//  Latency: 1-cycle imem gives ISSUE->WAIT->HOLD; first if_valid_o 3 cycles after reset release.
//  Peak throughput 1 instr/3 cycles with id_ready_i=1.
//  All outputs registered or decoded from state_q; no comb path from id_ready_i to if_valid_o.
//  rst_i mid-operation: outstanding imem response after reset is ignored only if it arrives in ISSUE (rsp in ISSUE always ignored).
// STRUCTURE
//  fetch_pkg:
//  - fetch_state_e {ISSUE, WAIT, HOLD, FAULT}
//  - localparam PC_STEP=4
//  - function is_misaligned(pc)
//  Sub-module: one adder (ADDER_WIDTH=XLEN, IS_SUBTRACTER=0) computing pc_q+PC_STEP.
//  Single always_ff for pc_q/state_q/drop_q/IF-ID regs; always_comb for next-state.
// TESTING
//  1 Reset, 1-cycle imem, id_ready_i=1 -> addrs 0x0,0x4,0x8; if_valid_o 3 cycles after reset; if_pc_plus4_o=0x4 for first entry.
//  2 id_ready_i=0 for 5 cycles in HOLD -> if_valid_o, if_pc_o=0x4, if_instr_o stable; no new imem_req_valid_o.
//  3 Redirect to 0x100 in WAIT before rsp (rdata 0xDEAD_BEEF) -> word dropped; next req addr 0x100; its word appears with if_pc_o=0x100.
//  4 Redirect to 0x200 same cycle as rsp, and separately in HOLD with id_ready_i=1 -> entry never handed over; next req addr 0x200.
//  5 RESET_VECTOR=32'hFFFF_FFFC -> first if_pc_plus4_o=0x0; second fetch addr 0x0.
//  6 Redirect to 0x102 -> fetch_fault_o=1 next cycle, imem_req_valid_o=0 forever; rst_i clears; fetch resumes at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states
//   PC_STEP       : byte distance between sequential instructions
//   is_misaligned : true when a PC's low two bits are not zero
package fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,  // request valid, waiting for imem to accept
    WAIT  = 2'd1,  // request accepted, waiting for the response
    HOLD  = 2'd2,  // IF/ID entry valid, waiting for decode
    FAULT = 2'd3   // misaligned redirect seen; parked until reset
  } fetch_state_e;

  localparam int PC_STEP = 4;

  // Only the two low PC bits matter for word alignment.
  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return (pc_lo != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_stage_adder.sv
// Plain combinational adder/subtracter used for the pc+4 computation.
//   a, b   : operands
//   result : a + b (or a - b when IS_SUBTRACTER), modulo 2^ADDER_WIDTH
module fetch_stage_adder #(
  parameter int ADDER_WIDTH   = 32,
  parameter bit IS_SUBTRACTER = 1'b0
) (
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  output logic [ADDER_WIDTH-1:0] result
);

  generate
    if (IS_SUBTRACTER) begin : g_sub
      assign result = a - b;
    end else begin : g_add
      assign result = a + b;
    end
  endgenerate

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the architectural PC, keeps at most one
// instruction-memory request outstanding and buffers the returned word in a
// one-entry IF/ID register handed to decode with a valid/ready handshake.
// Redirects from execute override everything; a response belonging to a
// request issued before a redirect is silently dropped.
//
// Ports
//   clk_i, rst_i        : clock (rising edge), synchronous active-high reset
//   redirect_valid_i/pc : execute redirects fetch to redirect_pc_i
//   imem_req_*          : request channel (valid/ready, address = current PC)
//   imem_rsp_valid_i    : one response per accepted request, >= 1 cycle later
//   imem_rdata_i        : instruction word returned with the response
//   if_valid_o          : IF/ID entry valid; id_ready_i consumes it
//   if_pc_o/_plus4_o    : PC of the buffered instruction and PC+4
//   if_instr_o          : buffered instruction word
//   fetch_fault_o       : sticky misaligned-redirect indication
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            if_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_pc_plus4_o,
  output logic [31:0]     if_instr_o,
  output logic            fetch_fault_o
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            drop_reg, drop_next;
  logic [XLEN-1:0] if_pc_reg, if_pc_plus4_reg;
  logic [31:0]     if_instr_reg;
  logic [XLEN-1:0] pc_plus4;
  logic            capture;
  logic            redirect_bad;

  fetch_stage_adder #(
    .ADDER_WIDTH   (XLEN),
    .IS_SUBTRACTER (1'b0)
  ) u_pc_adder (
    .a      (pc_reg),
    .b      (STEP),
    .result (pc_plus4)
  );

  assign redirect_bad = redirect_valid_i && is_misaligned(redirect_pc_i[1:0]);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    drop_next  = drop_reg;
    capture    = 1'b0;

    if (redirect_bad) begin
      // Misaligned target: park in FAULT from any state.
      state_next = FAULT;
      pc_next    = redirect_pc_i;
      drop_next  = 1'b0;
    end else begin
      unique case (state_reg)
        ISSUE: begin
          if (redirect_valid_i) begin
            pc_next = redirect_pc_i;
          end
          if (imem_req_ready_i) begin
            state_next = WAIT;
            // The accepted request was for the old PC; its data is stale.
            if (redirect_valid_i) begin
              drop_next = 1'b1;
            end
          end
        end
        WAIT: begin
          if (redirect_valid_i) begin
            pc_next = redirect_pc_i;
            if (imem_rsp_valid_i) begin
              // Response consumed here, so nothing stays outstanding.
              state_next = ISSUE;
              drop_next  = 1'b0;
            end else begin
              drop_next = 1'b1;
            end
          end else if (imem_rsp_valid_i) begin
            if (drop_reg) begin
              drop_next  = 1'b0;
              state_next = ISSUE;
            end else begin
              capture    = 1'b1;
              pc_next    = pc_plus4;
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid_i) begin
            pc_next    = redirect_pc_i;
            state_next = ISSUE;
          end else if (id_ready_i) begin
            state_next = ISSUE;
          end
        end
        default: begin
          // FAULT: only reset leaves this state.
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= ISSUE;
      pc_reg          <= RESET_VECTOR;
      drop_reg        <= 1'b0;
      if_pc_reg       <= '0;
      if_pc_plus4_reg <= '0;
      if_instr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      drop_reg  <= drop_next;
      if (capture) begin
        if_pc_reg       <= pc_reg;
        if_pc_plus4_reg <= pc_plus4;
        if_instr_reg    <= imem_rdata_i;
      end
    end
  end

  // Handshake outputs are pure state decodes: no combinational input paths.
  assign imem_req_valid_o = (state_reg == ISSUE);
  assign imem_addr_o      = pc_reg;
  assign if_valid_o       = (state_reg == HOLD);
  assign fetch_fault_o    = (state_reg == FAULT);
  assign if_pc_o          = if_pc_reg;
  assign if_pc_plus4_o    = if_pc_plus4_reg;
  assign if_instr_o       = if_instr_reg;

endmodule
